// File: rtl/vector_multiplier_pkg.sv
// Shared defaults and types for the lane-wise vector multiplier.
package vector_multiplier_pkg;

  localparam int unsigned DEF_WEIGHT_WIDTH  = 5;
  localparam int unsigned DEF_FEATURE_WIDTH = 8;
  localparam int unsigned DEF_FEATURE_ROWS  = 6;
  localparam int unsigned DEF_WEIGHT_ROWS   = 6;
  localparam int unsigned DEF_FEATURE_COLS  = 6;
  localparam int unsigned DEF_WEIGHT_COLS   = 3;
  localparam bit          DEF_SATURATE      = 1'b0;

  // Full-width lane product at the default widths; the multiply itself never overflows.
  typedef logic [DEF_WEIGHT_WIDTH+DEF_FEATURE_WIDTH-1:0] vm_prod_t;

endpackage

// File: rtl/vector_multiplier_lane.sv
// One lane: unsigned weight x feature, reduced to FEATURE_WIDTH by truncation or clamping.
module vm_lane
  import vector_multiplier_pkg::*;
#(
  parameter int unsigned WEIGHT_WIDTH  = DEF_WEIGHT_WIDTH,
  parameter int unsigned FEATURE_WIDTH = DEF_FEATURE_WIDTH,
  parameter bit          SATURATE      = DEF_SATURATE
) (
  input  logic [WEIGHT_WIDTH-1:0]  weight_i,
  input  logic [FEATURE_WIDTH-1:0] feature_i,
  output logic [FEATURE_WIDTH-1:0] product_o
);

  localparam int unsigned PW = WEIGHT_WIDTH + FEATURE_WIDTH;

  logic [PW-1:0] prod_s;
  logic          ovf_s;

  // Multiply at full width, then truncate or clamp to the output width.
  always_comb begin
    prod_s = {{FEATURE_WIDTH{1'b0}}, weight_i} * {{WEIGHT_WIDTH{1'b0}}, feature_i};
    ovf_s  = |prod_s[PW-1:FEATURE_WIDTH];
    if (SATURATE && ovf_s) begin
      product_o = {FEATURE_WIDTH{1'b1}};
    end else begin
      product_o = prod_s[FEATURE_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/vector_multiplier.sv
// Lane-wise weight x feature multiplier with a registered result and one-cycle latency.
module vector_multiplier
  import vector_multiplier_pkg::*;
#(
  parameter int unsigned WEIGHT_WIDTH  = DEF_WEIGHT_WIDTH,
  parameter int unsigned FEATURE_WIDTH = DEF_FEATURE_WIDTH,
  parameter int unsigned FEATURE_ROWS  = DEF_FEATURE_ROWS,
  parameter int unsigned WEIGHT_ROWS   = DEF_WEIGHT_ROWS,
  parameter int unsigned FEATURE_COLS  = DEF_FEATURE_COLS,
  parameter int unsigned WEIGHT_COLS   = DEF_WEIGHT_COLS,
  parameter bit          SATURATE      = DEF_SATURATE
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [WEIGHT_WIDTH-1:0]  scratchpad_in  [0:WEIGHT_ROWS-1],
  input  logic [FEATURE_WIDTH-1:0] features_in    [0:FEATURE_ROWS-1],
  output logic                     out_valid,
  output logic [FEATURE_WIDTH-1:0] vector_mul_out [0:FEATURE_ROWS-1]
);

  if (WEIGHT_ROWS != FEATURE_ROWS) begin : g_rows_check
    $error("vector_multiplier: WEIGHT_ROWS must equal FEATURE_ROWS");
  end

  logic [FEATURE_WIDTH-1:0] lane_s [0:FEATURE_ROWS-1];
  logic [FEATURE_WIDTH-1:0] vec_d  [0:FEATURE_ROWS-1];
  logic [FEATURE_WIDTH-1:0] vec_q  [0:FEATURE_ROWS-1];
  logic                     valid_d;
  logic                     valid_q;

  for (genvar gi = 0; gi < FEATURE_ROWS; gi++) begin : g_lane
    vm_lane #(
      .WEIGHT_WIDTH (WEIGHT_WIDTH),
      .FEATURE_WIDTH(FEATURE_WIDTH),
      .SATURATE     (SATURATE)
    ) u_lane (
      .weight_i (scratchpad_in[gi]),
      .feature_i(features_in[gi]),
      .product_o(lane_s[gi])
    );
  end

  // Capture lane results only when the input is valid; otherwise hold, so idle inputs are never sampled.
  always_comb begin
    valid_d = 1'b0;
    for (int i = 0; i < FEATURE_ROWS; i++) begin
      vec_d[i] = vec_q[i];
    end
    if (in_valid) begin
      valid_d = 1'b1;
      for (int i = 0; i < FEATURE_ROWS; i++) begin
        vec_d[i] = lane_s[i];
      end
    end else begin
      valid_d = 1'b0;
    end
  end

  // Output register array and valid flop; reset wins over in_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      for (int i = 0; i < FEATURE_ROWS; i++) begin
        vec_q[i] <= {FEATURE_WIDTH{1'b0}};
      end
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < FEATURE_ROWS; i++) begin
        vec_q[i] <= vec_d[i];
      end
    end
  end

  assign out_valid      = valid_q;
  assign vector_mul_out = vec_q;

endmodule

// File: tb/tb_vector_multiplier.sv
// Directed bench: a truncating and a saturating instance share stimulus and are checked every step.
module tb_vector_multiplier;
  import vector_multiplier_pkg::*;

  localparam int N = 6;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [4:0] sp    [0:N-1];
  logic [7:0] ft    [0:N-1];
  logic       vld_t;
  logic       vld_s;
  logic [7:0] out_t [0:N-1];
  logic [7:0] out_s [0:N-1];
  logic [7:0] exp_t [0:N-1];
  logic [7:0] exp_s [0:N-1];

  int n_assert;
  int n_fail;

  vector_multiplier #(.SATURATE(1'b0)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .scratchpad_in(sp), .features_in(ft),
    .out_valid(vld_t), .vector_mul_out(out_t)
  );

  vector_multiplier #(.SATURATE(1'b1)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .scratchpad_in(sp), .features_in(ft),
    .out_valid(vld_s), .vector_mul_out(out_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] mdl(input logic [4:0] w, input logic [7:0] f, input bit sat);
    vm_prod_t p;
    p = vm_prod_t'(w) * vm_prod_t'(f);
    if (sat && p > 13'd255) return 8'd255;
    return p[7:0];
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic chk_all(input string tag, input logic exp_vld);
    chk({tag, "_valid_t"}, {7'd0, vld_t}, {7'd0, exp_vld});
    chk({tag, "_valid_s"}, {7'd0, vld_s}, {7'd0, exp_vld});
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s_trunc[%0d]", tag, i), out_t[i], exp_t[i]);
      chk($sformatf("%s_sat[%0d]", tag, i), out_s[i], exp_s[i]);
    end
  endtask

  task automatic model_inputs();
    for (int i = 0; i < N; i++) begin
      exp_t[i] = mdl(sp[i], ft[i], 1'b0);
      exp_s[i] = mdl(sp[i], ft[i], 1'b1);
    end
  endtask

  task automatic randomize_inputs();
    for (int i = 0; i < N; i++) begin
      sp[i] = 5'($urandom_range(0, 31));
      ft[i] = 8'($urandom_range(0, 255));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] st_t [0:3][0:N-1];
    logic [7:0] st_s [0:3][0:N-1];
    n_assert = 0;
    n_fail   = 0;

    // Reset held two cycles with valid random inputs
    reset = 1'b1;
    in_valid = 1'b1;
    randomize_inputs();
    for (int i = 0; i < N; i++) begin
      exp_t[i] = 8'd0;
      exp_s[i] = 8'd0;
    end
    tick();
    chk_all("reset1", 1'b0);
    randomize_inputs();
    tick();
    chk_all("reset2", 1'b0);

    // Ramp: hand-computed products
    reset = 1'b0;
    for (int i = 0; i < N; i++) begin
      sp[i] = 5'(i);
      ft[i] = 8'(10 + i);
    end
    tick();
    exp_t[0] = 8'd0;  exp_t[1] = 8'd11; exp_t[2] = 8'd24;
    exp_t[3] = 8'd39; exp_t[4] = 8'd56; exp_t[5] = 8'd75;
    for (int i = 0; i < N; i++) exp_s[i] = exp_t[i];
    chk_all("ramp", 1'b1);

    // Idle cycle with changed inputs: values hold, valid drops
    in_valid = 1'b0;
    randomize_inputs();
    tick();
    chk_all("ramp_hold", 1'b0);

    // Overflow: 31 x 255 = 7905
    in_valid = 1'b1;
    for (int i = 0; i < N; i++) begin
      sp[i] = 5'd31;
      ft[i] = 8'd255;
    end
    tick();
    for (int i = 0; i < N; i++) begin
      exp_t[i] = 8'd225;
      exp_s[i] = 8'd255;
    end
    chk_all("overflow", 1'b1);

    // Streaming: four back-to-back vectors, each result one cycle after its input
    for (int v = 0; v < 4; v++) begin
      randomize_inputs();
      for (int i = 0; i < N; i++) begin
        st_t[v][i] = mdl(sp[i], ft[i], 1'b0);
        st_s[v][i] = mdl(sp[i], ft[i], 1'b1);
      end
      tick();
      for (int i = 0; i < N; i++) begin
        exp_t[i] = st_t[v][i];
        exp_s[i] = st_s[v][i];
      end
      chk_all($sformatf("stream%0d", v), 1'b1);
    end

    // Reset mid-stream on the second of three valid vectors
    randomize_inputs();
    model_inputs();
    tick();
    chk_all("mid_a", 1'b1);
    randomize_inputs();
    reset = 1'b1;
    tick();
    for (int i = 0; i < N; i++) begin
      exp_t[i] = 8'd0;
      exp_s[i] = 8'd0;
    end
    chk_all("mid_reset", 1'b0);
    reset = 1'b0;
    randomize_inputs();
    model_inputs();
    tick();
    chk_all("mid_c", 1'b1);
    in_valid = 1'b0;
    randomize_inputs();
    tick();
    chk_all("mid_c_hold", 1'b0);

    // Lane independence: walk a single unit weight across the lanes
    in_valid = 1'b1;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        sp[i] = (i == k) ? 5'd1 : 5'd0;
        ft[i] = 8'(37 * i + 5);
      end
      tick();
      for (int i = 0; i < N; i++) begin
        exp_t[i] = (i == k) ? 8'(37 * i + 5) : 8'd0;
        exp_s[i] = exp_t[i];
      end
      chk_all($sformatf("walk%0d", k), 1'b1);
    end

    in_valid = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
